// File: rtl/utils_pkg.sv
// utils_pkg: shared Gray-code helpers and the counter end-of-range mode.
//   GrayWordWidth  widest word the Gray helpers handle (32 bits)
//   gray_mode_e    GRAY_WRAP (modulo stepping) / GRAY_SATURATE (blocked at ends)
//   bin_to_gray    binary -> reflected Gray
//   gray_to_bin    reflected Gray -> binary
//   count_bits     population count, handy for Gray adjacency checks
package utils_pkg;

  localparam int GrayWordWidth = 32;

  typedef enum logic {GRAY_WRAP, GRAY_SATURATE} gray_mode_e;

  function automatic logic [GrayWordWidth-1:0] bin_to_gray(
    input logic [GrayWordWidth-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GrayWordWidth-1:0] gray_to_bin(
    input logic [GrayWordWidth-1:0] g
  );
    logic [GrayWordWidth-1:0] b;
    b[GrayWordWidth-1] = g[GrayWordWidth-1];
    for (int i = GrayWordWidth-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int count_bits(input logic [GrayWordWidth-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < GrayWordWidth; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/gray_step_counter.sv
// gray_step_counter: parametrised up/down counter with registered binary and
// Gray outputs plus end-of-range status.
//   Width (2..GrayWordWidth), ResetValue (< 2**Width), Mode (wrap/saturate)
// Ports:
//   clk_i, rst_i          clock (rising), async active-high reset
//   clr_i                 sync clear to ResetValue, clears sat_o
//   load_i, load_value_i  sync load, clears sat_o (clr_i wins)
//   en_i, up_i            one step per enabled cycle, up_i=1 increments
//   bin_o, gray_o         registered count and its Gray code
//   at_max_o, at_min_o    registered end-of-range flags
//   wrap_o                one-cycle pulse after a wrapping step
//   sat_o                 sticky: a step was blocked in saturate mode
// Every output is a flop; all are updated from the same next-state value so
// bin_o and gray_o always change on the same edge.
module gray_step_counter
  import utils_pkg::*;
#(
  parameter int               Width      = 4,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter gray_mode_e       Mode       = GRAY_WRAP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [Width-1:0] bin_o,
  output logic [Width-1:0] gray_o,
  output logic             at_max_o,
  output logic             at_min_o,
  output logic             wrap_o,
  output logic             sat_o
);

  // Zero-extend into the shared helper and keep only the low Width bits.
  function automatic logic [Width-1:0] to_gray(input logic [Width-1:0] b);
    logic [GrayWordWidth-1:0] w;
    w = bin_to_gray(GrayWordWidth'(b));
    return w[Width-1:0];
  endfunction

  localparam logic [Width-1:0] MaxVal  = '1;
  localparam logic [Width-1:0] MinVal  = '0;
  localparam logic [Width-1:0] RstGray = to_gray(ResetValue);
  localparam logic             Sat     = (Mode == GRAY_SATURATE);

  logic [Width-1:0] next_bin;
  logic             next_wrap;
  logic             next_sat;

  always_comb begin
    next_bin  = bin_o;
    next_wrap = 1'b0;
    next_sat  = sat_o;
    if (clr_i) begin
      next_bin = ResetValue;
      next_sat = 1'b0;
    end else if (load_i) begin
      next_bin = load_value_i;
      next_sat = 1'b0;
    end else if (en_i) begin
      if (up_i) begin
        if (bin_o == MaxVal) begin
          // End of range: saturate blocks the step, wrap rolls over to 0.
          if (Sat) next_sat = 1'b1;
          else begin
            next_bin  = MinVal;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = bin_o + Width'(1);
        end
      end else begin
        if (bin_o == MinVal) begin
          if (Sat) next_sat = 1'b1;
          else begin
            next_bin  = MaxVal;
            next_wrap = 1'b1;
          end
        end else begin
          next_bin = bin_o - Width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_o    <= ResetValue;
      gray_o   <= RstGray;
      at_max_o <= (ResetValue == MaxVal);
      at_min_o <= (ResetValue == MinVal);
      wrap_o   <= 1'b0;
      sat_o    <= 1'b0;
    end else begin
      bin_o    <= next_bin;
      gray_o   <= to_gray(next_bin);
      at_max_o <= (next_bin == MaxVal);
      at_min_o <= (next_bin == MinVal);
      wrap_o   <= next_wrap;
      sat_o    <= next_sat;
    end
  end

endmodule

// File: tb/tb_gray_step_counter.sv
// Testbench for gray_step_counter. Four instances share one stimulus stream:
//   u0: Width=4,  ResetValue=0, wrap
//   u1: Width=4,  ResetValue=0, saturate
//   u2: Width=4,  ResetValue=5, wrap
//   u3: Width=32, ResetValue=0, wrap
// An arithmetic model tracks every instance and is compared on each falling
// edge; directed literal checks after each edge pin the model down.
module tb_gray_step_counter;
  import utils_pkg::*;

  localparam int NI = 4;
  localparam int WID [NI] = '{4, 4, 4, 32};
  localparam int RV  [NI] = '{0, 0, 5, 0};
  localparam bit SATM[NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst, clr, load, en, up;
  logic [31:0] lv;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  b0, g0, b1, g1, b2, g2;
  logic [31:0] b3, g3;
  logic [NI-1:0] amax, amin, wr, st;

  gray_step_counter #(.Width(4), .ResetValue(4'd0), .Mode(GRAY_WRAP)) u0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_value_i(lv[3:0]),
    .en_i(en), .up_i(up), .bin_o(b0), .gray_o(g0), .at_max_o(amax[0]),
    .at_min_o(amin[0]), .wrap_o(wr[0]), .sat_o(st[0]));
  gray_step_counter #(.Width(4), .ResetValue(4'd0), .Mode(GRAY_SATURATE)) u1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_value_i(lv[3:0]),
    .en_i(en), .up_i(up), .bin_o(b1), .gray_o(g1), .at_max_o(amax[1]),
    .at_min_o(amin[1]), .wrap_o(wr[1]), .sat_o(st[1]));
  gray_step_counter #(.Width(4), .ResetValue(4'd5), .Mode(GRAY_WRAP)) u2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_value_i(lv[3:0]),
    .en_i(en), .up_i(up), .bin_o(b2), .gray_o(g2), .at_max_o(amax[2]),
    .at_min_o(amin[2]), .wrap_o(wr[2]), .sat_o(st[2]));
  gray_step_counter #(.Width(32), .ResetValue(32'd0), .Mode(GRAY_WRAP)) u3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_value_i(lv),
    .en_i(en), .up_i(up), .bin_o(b3), .gray_o(g3), .at_max_o(amax[3]),
    .at_min_o(amin[3]), .wrap_o(wr[3]), .sat_o(st[3]));

  logic [31:0] bin_a [NI];
  logic [31:0] gray_a[NI];
  always_comb begin
    bin_a[0] = 32'(b0); gray_a[0] = 32'(g0);
    bin_a[1] = 32'(b1); gray_a[1] = 32'(g1);
    bin_a[2] = 32'(b2); gray_a[2] = 32'(g2);
    bin_a[3] = b3;      gray_a[3] = g3;
  end

  int npass = 0, ntot = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // kind: 0 = value unchanged, 1 = unblocked single step, 2 = clr/load to a new value
  function automatic longint maxv(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  longint mbin[NI];
  logic   mwrap[NI], msat[NI];
  int     mkind[NI];
  longint nb_a[NI];
  logic   nw_a[NI], ns_a[NI];
  int     nk_a[NI];

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      nb_a[i] = mbin[i];
      nw_a[i] = 1'b0;
      ns_a[i] = msat[i];
      nk_a[i] = 0;
      if (clr) begin
        nb_a[i] = RV[i];
        ns_a[i] = 1'b0;
        nk_a[i] = (longint'(RV[i]) == mbin[i]) ? 0 : 2;
      end else if (load) begin
        nb_a[i] = longint'(lv) & maxv(WID[i]);
        ns_a[i] = 1'b0;
        nk_a[i] = ((longint'(lv) & maxv(WID[i])) == mbin[i]) ? 0 : 2;
      end else if (en) begin
        if (up && mbin[i] == maxv(WID[i])) begin
          if (SATM[i]) ns_a[i] = 1'b1;
          else begin nb_a[i] = 0; nw_a[i] = 1'b1; nk_a[i] = 1; end
        end else if (!up && mbin[i] == 0) begin
          if (SATM[i]) ns_a[i] = 1'b1;
          else begin nb_a[i] = maxv(WID[i]); nw_a[i] = 1'b1; nk_a[i] = 1; end
        end else begin
          nb_a[i] = up ? mbin[i] + 1 : mbin[i] - 1;
          nk_a[i] = 1;
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mbin[i] <= RV[i]; mwrap[i] <= 1'b0; msat[i] <= 1'b0; mkind[i] <= 2;
      end else begin
        mbin[i] <= nb_a[i]; mwrap[i] <= nw_a[i]; msat[i] <= ns_a[i]; mkind[i] <= nk_a[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int rst_cnt = 0, rst_seen = 0;
  always @(posedge rst) rst_cnt <= rst_cnt + 1;

  logic [31:0] gprev[NI];
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("u%0d.bin", i), longint'(bin_a[i]), mbin[i]);
        chk($sformatf("u%0d.gray", i), longint'(gray_a[i]), mbin[i] ^ (mbin[i] >> 1));
        chk($sformatf("u%0d.at_max", i), longint'(amax[i]), longint'(mbin[i] == maxv(WID[i])));
        chk($sformatf("u%0d.at_min", i), longint'(amin[i]), longint'(mbin[i] == 0));
        chk($sformatf("u%0d.wrap", i), longint'(wr[i]), longint'(mwrap[i]));
        chk($sformatf("u%0d.sat", i), longint'(st[i]), longint'(msat[i]));
        chk($sformatf("u%0d.g2b", i), longint'(gray_to_bin(gray_a[i])), mbin[i]);
        if (rst_cnt == rst_seen && mkind[i] != 2)
          chk($sformatf("u%0d.gray_bits_changed", i),
              longint'(count_bits(gray_a[i] ^ gprev[i])), longint'(mkind[i]));
      end
    end
    for (int i = 0; i < NI; i++) gprev[i] <= gray_a[i];
    rst_seen <= rst_cnt;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] gtbl[16];

  initial begin
    gtbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; lv = '0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    // reset state
    chk("rst.u0.bin", longint'(b0), 0);
    chk("rst.u0.gray", longint'(g0), 0);
    chk("rst.u0.at_min", longint'(amin[0]), 1);
    chk("rst.u0.at_max", longint'(amax[0]), 0);
    chk("rst.u2.bin", longint'(b2), 5);
    chk("rst.u2.gray", longint'(g2), 7);
    chk("rst.wrap_sat", longint'({wr, st}), 0);

    // 1: count up 17 steps through the wrap
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("t1.bin[%0d]", k), longint'(b0), k % 16);
      chk($sformatf("t1.gray[%0d]", k), longint'(g0), longint'(gtbl[k % 16]));
      chk($sformatf("t1.wrap[%0d]", k), longint'(wr[0]), longint'(k == 16));
    end

    // 2: down from 0 wraps to 15
    en = 1'b0;
    pulse_rst();
    en = 1'b1; up = 1'b0;
    tick();
    chk("t2.bin", longint'(b0), 15);
    chk("t2.gray", longint'(g0), 8);
    chk("t2.wrap", longint'(wr[0]), 1);
    chk("t2.at_max", longint'(amax[0]), 1);
    chk("t2.u1_sat_down", longint'(st[1]), 1);
    en = 1'b0;
    tick();
    chk("t2.wrap_drop", longint'(wr[0]), 0);

    // 3: saturate at the top
    load = 1'b1; lv = 32'd14;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    chk("t3.load14", longint'(b1), 14);
    tick();
    chk("t3.s1.bin", longint'(b1), 15);
    chk("t3.s1.sat", longint'(st[1]), 0);
    for (int k = 2; k <= 3; k++) begin
      tick();
      chk($sformatf("t3.s%0d.bin", k), longint'(b1), 15);
      chk($sformatf("t3.s%0d.gray", k), longint'(g1), 8);
      chk($sformatf("t3.s%0d.sat", k), longint'(st[1]), 1);
      chk($sformatf("t3.s%0d.wrap", k), longint'(wr[1]), 0);
    end
    en = 1'b0; load = 1'b1; lv = 32'd3;
    tick();
    load = 1'b0;
    chk("t3.load3.bin", longint'(b1), 3);
    chk("t3.load3.gray", longint'(g1), 2);
    chk("t3.load3.sat", longint'(st[1]), 0);

    // 4: priority clr > load > en
    pulse_rst();
    en = 1'b1; up = 1'b1;
    tick(); tick();
    chk("t4.u2_at7", longint'(b2), 7);
    clr = 1'b1; load = 1'b1; lv = 32'd9;
    tick();
    chk("t4.clr.bin", longint'(b2), 5);
    chk("t4.clr.gray", longint'(g2), 7);
    chk("t4.clr.wrap", longint'(wr[2]), 0);
    clr = 1'b0; en = 1'b0; lv = 32'd7;
    tick();
    en = 1'b1; lv = 32'd9;
    tick();
    chk("t4.load.bin", longint'(b2), 9);
    chk("t4.load.gray", longint'(g2), 13);
    // load while at max with en: no wrap pulse
    lv = 32'd15;
    tick(); tick();
    chk("t4.load_at_max.bin", longint'(b0), 15);
    chk("t4.load_at_max.wrap", longint'(wr[0]), 0);

    // 5: asynchronous reset between edges
    en = 1'b0; lv = 32'd6;
    tick();
    load = 1'b0;
    chk("t5.u0_at6", longint'(b0), 6);
    en = 1'b1; up = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5.async.u0.bin", longint'(b0), 0);
    chk("t5.async.u0.gray", longint'(g0), 0);
    chk("t5.async.u0.at_min", longint'(amin[0]), 1);
    chk("t5.async.u2.bin", longint'(b2), 5);
    #1;
    rst = 1'b0;
    tick();
    chk("t5.resume.u0", longint'(b0), 1);
    chk("t5.resume.u2", longint'(b2), 6);

    // 6: 32-bit wrap
    en = 1'b0; load = 1'b1; lv = 32'hFFFF_FFFE;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("t6.s1.bin", longint'(b3), 64'hFFFF_FFFF);
    chk("t6.s1.gray", longint'(g3), 64'h8000_0000);
    chk("t6.s1.wrap", longint'(wr[3]), 0);
    tick();
    chk("t6.s2.bin", longint'(b3), 0);
    chk("t6.s2.gray", longint'(g3), 0);
    chk("t6.s2.wrap", longint'(wr[3]), 1);
    en = 1'b0;
    tick();
    chk("t6.wrap_drop", longint'(wr[3]), 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/gray_step_counter.md
Name: gray_step_counter

Overview:
- Parametrised up/down counter that produces registered binary and Gray-coded outputs together.
- Successor to the fixed 32-bit bin/gray helpers in utils_pkg: adds configurable width, direction, load/clear, a wrap-or-saturate mode, and status flags.
- Used as the pointer/sequence generator in FIFOs and other counters.
- Its Gray output is registered, so it is safe to sample downstream.

Parameters:
- Width, 4, counter width in bits; legal range 2..32 (limited by utils_pkg::GrayWordWidth).
- ResetValue, 0, binary value taken on reset and on clear; must be below 2**Width.
- Mode, utils_pkg::GRAY_WRAP, GRAY_WRAP or GRAY_SATURATE behaviour at the end of the range.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- clr_i  input  1  synchronous clear to ResetValue; also clears sat_o.
- load_i  input  1  synchronous load of load_value_i; also clears sat_o.
- load_value_i  input  Width  binary value to load.
- en_i  input  1  count enable; one step per cycle.
- up_i  input  1  direction: 1 = increment, 0 = decrement.
- bin_o  output  Width  registered binary count.
- gray_o  output  Width  registered Gray encoding of bin_o.
- at_max_o  output  1  registered; high when bin_o == 2**Width-1.
- at_min_o  output  1  registered; high when bin_o == 0.
- wrap_o  output  1  one-cycle pulse marking a wrap transition.
- sat_o  output  1  sticky flag: a step was blocked in saturate mode.

Behaviour:
- Reset (async assert, sync-safe release) sets:
  - bin_o = ResetValue
  - gray_o = bin_to_gray(ResetValue)
  - at_max_o and at_min_o derived from ResetValue
  - wrap_o = 0, sat_o = 0
- All outputs are flops. There is no combinational path from any input to any output.
- Latency: an action sampled at edge N appears on every output after edge N.
- Per-cycle priority is clr_i > load_i > en_i > hold.
  - clr_i: next = ResetValue, sat_o = 0.
  - load_i: next = load_value_i, sat_o = 0.
  - en_i with up_i = 1: next = bin + 1.
  - en_i with up_i = 0: next = bin - 1.
  - Otherwise: hold.
- gray_o is computed from next_bin, not from bin_o, so gray_o and bin_o change on the same edge.
  - Use utils_pkg::bin_to_gray: zero-extend to GrayWordWidth, then truncate the result to Width.
- Step arithmetic is modulo 2**Width in wrap mode.
  - Up from 2**Width-1 goes to 0; down from 0 goes to 2**Width-1.
  - wrap_o is high for exactly the cycle following the wrapping edge.
  - sat_o stays 0 in wrap mode.
- Saturate mode:
  - An up step at max, or a down step at 0, leaves bin_o and gray_o unchanged.
  - wrap_o stays 0.
  - sat_o sets on the next edge and holds until clr_i, load_i, or reset.
  - An up step at 0, or a down step at max, is a normal step.
- Gray invariant: every enabled, unblocked step changes exactly one bit of gray_o; this includes the wrap step.
  - Hold, blocked steps, and clr/load of the current value change no bits.
  - clr/load of a different value may change several bits and is exempt from the invariant.
- wrap_o is 0 on any cycle selected by clr_i or load_i, even when en_i is also high.
- Direction may change on any cycle; there is no turnaround penalty.
- Reset asserted mid-count forces the reset values asynchronously and discards any in-flight step.

Decomposition:
- Add to utils_pkg:
  - typedef enum logic {GRAY_WRAP, GRAY_SATURATE} gray_mode_e.
  - No new functions; bin_to_gray and gray_to_bin are reused.
- Single flat module; no sub-module is warranted.
- The bench uses utils_pkg::gray_to_bin and count_bits for checking:
  - gray_to_bin(gray_o) == bin_o every cycle.
  - count_bits(gray_o ^ gray_prev) == 1 on every unblocked step.

Test Plan:
1. Width=4, wrap mode, reset then en_i=1, up_i=1 for 17 cycles:
   - bin_o goes 0..15, 0.
   - gray_o goes 0000,0001,0011,...,1000, then 0000.
   - wrap_o pulses once, after the 15->0 edge.
   - One Gray bit changes per step.
2. Width=4, wrap mode, reset, then en_i=1, up_i=0 for one cycle:
   - bin_o=15, gray_o=1000, wrap_o pulses, at_max_o=1.
3. Width=4, saturate mode, load 14, then up for 3 cycles:
   - bin_o goes 15, 15, 15; gray_o stays 1000.
   - sat_o=1 from the second step onward; wrap_o never asserts.
   - A subsequent load of 3 gives bin_o=3, gray_o=0010, sat_o=0.
4. Priority check: clr_i, load_i=1 (value 9) and en_i all high at bin_o=7, ResetValue=5:
   - Next cycle bin_o=5, gray_o=0111, wrap_o=0.
   - Same test with clr_i=0: bin_o=9, gray_o=1101.
5. Reset mid-operation: assert rst_i asynchronously between edges while bin_o=6:
   - Outputs go to ResetValue immediately, not waiting for an edge.
   - After release, counting resumes from ResetValue on the first enabled edge.
6. Width=32, wrap mode, load 0xFFFFFFFE, then up for 2 cycles:
   - bin_o goes 0xFFFFFFFF, then 0.
   - gray_o goes 0x80000000, then 0.
   - wrap_o pulses once.
   - gray_to_bin(gray_o) matches bin_o throughout.
